// File: rtl/flash_linebuf.sv
// Single-line (4 x 32-bit) read buffer between a Wishbone CPU port and a flash controller.
// Reads hit the held line or refill it in order; writes pass through and invalidate a matching line.
module flash_linebuf #(
    parameter int unsigned adr_width = 22,
    parameter int unsigned rd_words  = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        inval,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    output logic        s_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, ACK} state_t;

    state_t                 state, state_d;
    logic                   valid, valid_d;
    logic [1:0]             idx, idx_d;
    logic [1:0]             want, want_d;
    logic [adr_width-5:0]   tag, tag_d;
    logic                   fill_inv, fill_inv_d;
    logic [31:0]            s_dat_d, m_adr_d, m_dat_d;
    logic [3:0]             m_sel_d;
    logic                   s_ack_d, m_we_d, m_cyc_d, m_stb_d;
    logic                   line_we;
    logic [31:0]            words [rd_words];

    logic [adr_width-5:0]   req_tag;
    logic                   hit;

    assign req_tag = s_adr_i[adr_width-1:4];
    assign hit     = valid & (tag == req_tag) & ~inval;

    function automatic logic [31:0] line_adr(input logic [adr_width-5:0] t, input logic [1:0] i);
        logic [31:0] a;
        a = '0;
        a[adr_width-1:4] = t;
        a[3:2] = i;
        return a;
    endfunction

    always_comb begin
        state_d    = state;
        valid_d    = valid;
        idx_d      = idx;
        want_d     = want;
        tag_d      = tag;
        fill_inv_d = fill_inv;
        s_dat_d    = s_dat_o;
        s_ack_d    = 1'b0;
        m_adr_d    = m_adr_o;
        m_dat_d    = m_dat_o;
        m_sel_d    = m_sel_o;
        m_we_d     = m_we_o;
        m_cyc_d    = m_cyc_o;
        m_stb_d    = m_stb_o;
        line_we    = 1'b0;

        if (inval)
            valid_d = 1'b0;

        case (state)
            IDLE: begin
                // s_ack_o high means the CPU is still finishing the previous cycle
                if (s_cyc_i && s_stb_i && !s_ack_o) begin
                    if (s_we_i) begin
                        state_d = WRITE;
                        m_cyc_d = 1'b1;
                        m_stb_d = 1'b1;
                        m_we_d  = 1'b1;
                        m_adr_d = s_adr_i;
                        m_dat_d = s_dat_i;
                        m_sel_d = s_sel_i;
                    end else if (hit) begin
                        state_d = ACK;
                        s_dat_d = words[s_adr_i[3:2]];
                    end else begin
                        state_d    = FILL;
                        idx_d      = 2'd0;
                        tag_d      = req_tag;
                        want_d     = s_adr_i[3:2];
                        fill_inv_d = 1'b0;
                        m_cyc_d    = 1'b1;
                        m_stb_d    = 1'b1;
                        m_we_d     = 1'b0;
                        m_sel_d    = 4'b1111;
                        m_adr_d    = line_adr(req_tag, 2'd0);
                    end
                end
            end
            FILL: begin
                if (inval)
                    fill_inv_d = 1'b1;
                if (m_ack_i) begin
                    line_we = 1'b1;
                    idx_d   = idx + 2'd1;
                    m_adr_d = line_adr(tag, idx + 2'd1);
                    if (idx == 2'd3) begin
                        valid_d = ~(fill_inv | inval);
                        state_d = ACK;
                        m_cyc_d = 1'b0;
                        m_stb_d = 1'b0;
                        // word 3 is only arriving on this edge, so take it from the bus
                        s_dat_d = (want == 2'd3) ? m_dat_i : words[want];
                    end
                end
            end
            WRITE: begin
                if (m_ack_i) begin
                    state_d = ACK;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (m_adr_o[adr_width-1:4] == tag)
                        valid_d = 1'b0;
                end
            end
            ACK: begin
                s_ack_d = s_cyc_i & s_stb_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            valid    <= 1'b0;
            idx      <= '0;
            want     <= '0;
            tag      <= '0;
            fill_inv <= 1'b0;
            s_dat_o  <= '0;
            s_ack_o  <= 1'b0;
            m_adr_o  <= '0;
            m_dat_o  <= '0;
            m_sel_o  <= '0;
            m_we_o   <= 1'b0;
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
        end else begin
            state    <= state_d;
            valid    <= valid_d;
            idx      <= idx_d;
            want     <= want_d;
            tag      <= tag_d;
            fill_inv <= fill_inv_d;
            s_dat_o  <= s_dat_d;
            s_ack_o  <= s_ack_d;
            m_adr_o  <= m_adr_d;
            m_dat_o  <= m_dat_d;
            m_sel_o  <= m_sel_d;
            m_we_o   <= m_we_d;
            m_cyc_o  <= m_cyc_d;
            m_stb_o  <= m_stb_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (line_we)
            words[idx] <= m_dat_i;
    end

endmodule

// File: tb/tb_flash_linebuf.sv
// Directed bench for flash_linebuf: a one-cycle-gap flash slave model and per-scenario checks.
module tb_flash_linebuf;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        inval = 1'b0;
    logic [31:0] s_adr_i = '0, s_dat_i = '0, s_dat_o;
    logic [3:0]  s_sel_i = '0;
    logic        s_we_i = 1'b0, s_cyc_i = 1'b0, s_stb_i = 1'b0, s_ack_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o;
    logic        m_ack_i = 1'b0;

    int vec = 0;
    int miss = 0;

    int          mlog_n = 0;
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic [3:0]  log_sel [64];
    logic        log_we  [64];
    int          sack_n = 0;
    int          adj_n = 0;
    logic        sack_prev = 1'b0;

    flash_linebuf #(.adr_width(22)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .inval(inval),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_sel_i(s_sel_i),
        .s_we_i(s_we_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] fw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign m_dat_i = fw(m_adr_o);

    // Slave acks each strobed cycle, then idles one cycle before the next ack
    always @(posedge sys_clk) m_ack_i <= m_cyc_o & m_stb_o & ~m_ack_i;

    always @(posedge sys_clk) begin
        if (m_cyc_o && m_stb_o && m_ack_i) begin
            if (mlog_n < 64) begin
                log_adr[mlog_n] <= m_adr_o;
                log_dat[mlog_n] <= m_dat_o;
                log_sel[mlog_n] <= m_sel_o;
                log_we[mlog_n]  <= m_we_o;
            end
            mlog_n <= mlog_n + 1;
        end
        if (s_ack_o) sack_n <= sack_n + 1;
        if (s_ack_o && sack_prev) adj_n <= adj_n + 1;
        sack_prev <= s_ack_o;
    end

    task automatic start_req(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] sel);
        s_adr_i = a; s_we_i = we; s_dat_i = d; s_sel_i = sel;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
    endtask

    task automatic release_req();
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    // n = negedges until s_ack_o is seen, -1 if the budget runs out
    task automatic wait_sack(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge sys_clk);
            if (s_ack_o) begin n = i; break; end
        end
    endtask

    task automatic wait_log(input int base, input int cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mlog_n - base >= cnt) begin ok = 1'b1; break; end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        vec++; if (s_ack_o !== 1'b0) begin miss++; $display("FAIL rst_s_ack got %b want 0", s_ack_o); end
        vec++; if (m_cyc_o !== 1'b0) begin miss++; $display("FAIL rst_m_cyc got %b want 0", m_cyc_o); end
        vec++; if (m_stb_o !== 1'b0) begin miss++; $display("FAIL rst_m_stb got %b want 0", m_stb_o); end
        vec++; if (m_we_o !== 1'b0) begin miss++; $display("FAIL rst_m_we got %b want 0", m_we_o); end
        vec++; if (s_dat_o !== 32'h0) begin miss++; $display("FAIL rst_s_dat got %h want 0", s_dat_o); end
        vec++; if (m_adr_o !== 32'h0) begin miss++; $display("FAIL rst_m_adr got %h want 0", m_adr_o); end
        vec++; if (m_sel_o !== 4'h0) begin miss++; $display("FAIL rst_m_sel got %h want 0", m_sel_o); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_cold_miss();
        int n, b;
        b = mlog_n;
        start_req(32'h108, 1'b0, '0, 4'hF);
        wait_sack(40, n);
        release_req();
        vec++; if (n !== 10) begin miss++; $display("FAIL miss_latency got %0d want 10", n); end
        vec++; if (mlog_n - b !== 4) begin miss++; $display("FAIL miss_count got %0d want 4", mlog_n - b); end
        for (int k = 0; k < 4; k++) begin
            vec++; if (log_adr[b+k] !== 32'h100 + 32'(4*k)) begin miss++; $display("FAIL miss_adr%0d got %h want %h", k, log_adr[b+k], 32'h100 + 32'(4*k)); end
            vec++; if (log_we[b+k] !== 1'b0 || log_sel[b+k] !== 4'hF) begin miss++; $display("FAIL miss_we_sel%0d got %b/%h want 0/f", k, log_we[b+k], log_sel[b+k]); end
        end
        vec++; if (s_dat_o !== fw(32'h108)) begin miss++; $display("FAIL miss_data got %h want %h", s_dat_o, fw(32'h108)); end
        @(negedge sys_clk);
    endtask

    task automatic test_hit();
        int n, b;
        b = mlog_n;
        start_req(32'h10C, 1'b0, '0, 4'h1);
        wait_sack(20, n);
        release_req();
        vec++; if (n !== 2) begin miss++; $display("FAIL hit_latency got %0d want 2", n); end
        vec++; if (s_dat_o !== fw(32'h10C)) begin miss++; $display("FAIL hit_data got %h want %h", s_dat_o, fw(32'h10C)); end
        @(negedge sys_clk);
        start_req(32'h100, 1'b0, '0, 4'hF);
        wait_sack(20, n);
        release_req();
        vec++; if (s_dat_o !== fw(32'h100)) begin miss++; $display("FAIL hit0_data got %h want %h", s_dat_o, fw(32'h100)); end
        vec++; if (mlog_n !== b) begin miss++; $display("FAIL hit_no_master got %0d want 0", mlog_n - b); end
        @(negedge sys_clk);
    endtask

    task automatic test_write_inval();
        int n, b;
        b = mlog_n;
        start_req(32'h104, 1'b1, 32'h0000DEAD, 4'b0011);
        wait_sack(20, n);
        release_req();
        vec++; if (n !== 4) begin miss++; $display("FAIL wr_latency got %0d want 4", n); end
        vec++; if (mlog_n - b !== 1) begin miss++; $display("FAIL wr_count got %0d want 1", mlog_n - b); end
        vec++; if (log_adr[b] !== 32'h104 || log_we[b] !== 1'b1) begin miss++; $display("FAIL wr_adr_we got %h/%b want 104/1", log_adr[b], log_we[b]); end
        vec++; if (log_sel[b] !== 4'b0011 || log_dat[b] !== 32'hDEAD) begin miss++; $display("FAIL wr_sel_dat got %h/%h want 3/dead", log_sel[b], log_dat[b]); end
        @(negedge sys_clk);
        b = mlog_n;
        start_req(32'h100, 1'b0, '0, 4'hF);
        wait_sack(40, n);
        release_req();
        vec++; if (n !== 10 || mlog_n - b !== 4) begin miss++; $display("FAIL wr_refetch got lat %0d cnt %0d want 10/4", n, mlog_n - b); end
        vec++; if (s_dat_o !== fw(32'h100)) begin miss++; $display("FAIL wr_refetch_data got %h want %h", s_dat_o, fw(32'h100)); end
        @(negedge sys_clk);
    endtask

    task automatic test_abort();
        int n, b, sa;
        bit ok;
        b = mlog_n;
        sa = sack_n;
        start_req(32'h200, 1'b0, '0, 4'hF);
        wait_log(b, 2, ok);
        release_req();
        vec++; if (!ok) begin miss++; $display("FAIL abort_wait got timeout want 2 acks"); end
        for (int i = 0; i < 40 && m_cyc_o; i++) @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        vec++; if (mlog_n - b !== 4) begin miss++; $display("FAIL abort_fill_count got %0d want 4", mlog_n - b); end
        vec++; if (sack_n !== sa) begin miss++; $display("FAIL abort_no_ack got %0d want 0", sack_n - sa); end
        b = mlog_n;
        start_req(32'h204, 1'b0, '0, 4'hF);
        wait_sack(20, n);
        release_req();
        vec++; if (n !== 2 || mlog_n !== b) begin miss++; $display("FAIL abort_hit got lat %0d cnt %0d want 2/0", n, mlog_n - b); end
        vec++; if (s_dat_o !== fw(32'h204)) begin miss++; $display("FAIL abort_hit_data got %h want %h", s_dat_o, fw(32'h204)); end
        @(negedge sys_clk);
    endtask

    task automatic test_reset_midfill();
        int n, b;
        bit ok;
        b = mlog_n;
        start_req(32'h300, 1'b0, '0, 4'hF);
        wait_log(b, 1, ok);
        sys_rst = 1'b1;
        release_req();
        @(negedge sys_clk);
        vec++; if (!ok) begin miss++; $display("FAIL rstfill_wait got timeout want 1 ack"); end
        vec++; if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || m_we_o !== 1'b0) begin miss++; $display("FAIL rstfill_strobes got %b%b%b want 000", m_cyc_o, m_stb_o, m_we_o); end
        vec++; if (m_adr_o !== 32'h0 || m_sel_o !== 4'h0 || s_dat_o !== 32'h0) begin miss++; $display("FAIL rstfill_regs got %h/%h/%h want 0", m_adr_o, m_sel_o, s_dat_o); end
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        b = mlog_n;
        start_req(32'h204, 1'b0, '0, 4'hF);
        wait_sack(40, n);
        release_req();
        vec++; if (n !== 10 || mlog_n - b !== 4) begin miss++; $display("FAIL rstfill_invalid got lat %0d cnt %0d want 10/4", n, mlog_n - b); end
        vec++; if (s_dat_o !== fw(32'h204)) begin miss++; $display("FAIL rstfill_data got %h want %h", s_dat_o, fw(32'h204)); end
        @(negedge sys_clk);
    endtask

    task automatic test_inval_fill();
        int n, b;
        bit ok;
        b = mlog_n;
        start_req(32'h40C, 1'b0, '0, 4'hF);
        wait_log(b, 1, ok);
        inval = 1'b1;
        @(negedge sys_clk);
        inval = 1'b0;
        wait_sack(40, n);
        release_req();
        vec++; if (!ok || n < 0) begin miss++; $display("FAIL inval_ack got ok %b lat %0d want ack", ok, n); end
        vec++; if (s_dat_o !== fw(32'h40C)) begin miss++; $display("FAIL inval_data got %h want %h", s_dat_o, fw(32'h40C)); end
        vec++; if (mlog_n - b !== 4) begin miss++; $display("FAIL inval_fill_count got %0d want 4", mlog_n - b); end
        @(negedge sys_clk);
        b = mlog_n;
        start_req(32'h40C, 1'b0, '0, 4'hF);
        wait_sack(40, n);
        release_req();
        vec++; if (n !== 10 || mlog_n - b !== 4) begin miss++; $display("FAIL inval_reread got lat %0d cnt %0d want 10/4", n, mlog_n - b); end
        vec++; if (s_dat_o !== fw(32'h40C)) begin miss++; $display("FAIL inval_reread_data got %h want %h", s_dat_o, fw(32'h40C)); end
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        int n, b, sa, aj;
        b = mlog_n;
        sa = sack_n;
        aj = adj_n;
        start_req(32'h404, 1'b0, '0, 4'hF);
        wait_sack(20, n);
        vec++; if (n !== 2 || s_dat_o !== fw(32'h404)) begin miss++; $display("FAIL b2b_first got lat %0d data %h want 2/%h", n, s_dat_o, fw(32'h404)); end
        s_adr_i = 32'h408;
        wait_sack(20, n);
        release_req();
        vec++; if (n !== 3 || s_dat_o !== fw(32'h408)) begin miss++; $display("FAIL b2b_second got lat %0d data %h want 3/%h", n, s_dat_o, fw(32'h408)); end
        repeat (2) @(negedge sys_clk);
        vec++; if (adj_n !== aj) begin miss++; $display("FAIL b2b_adjacent got %0d want 0", adj_n - aj); end
        vec++; if (sack_n - sa !== 2 || mlog_n !== b) begin miss++; $display("FAIL b2b_counts got acks %0d master %0d want 2/0", sack_n - sa, mlog_n - b); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_write_inval();
        test_abort();
        test_reset_midfill();
        test_inval_fill();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/flash_linebuf.md
FLASH_LINEBUF -- requirements
Module: flash_linebuf

Interface
REQ-001 The block SHALL have these parameters:
- adr_width, default 22: significant byte-address bits forwarded to the flash controller.
- rd_words, fixed 4: words per line.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- inval  in  1  one-cycle pulse that clears line valid.
- s_adr_i  in  32  CPU-side Wishbone slave byte address.
- s_dat_i  in  32  CPU write data.
- s_dat_o  out  32  CPU read data.
- s_sel_i  in  4  CPU byte selects.
- s_we_i  in  1  CPU write enable.
- s_cyc_i  in  1  CPU cycle.
- s_stb_i  in  1  CPU strobe.
- s_ack_o  out  1  CPU acknowledge.
- m_adr_o  out  32  flash-controller-side Wishbone master address.
- m_dat_o  out  32  write data to the flash controller.
- m_dat_i  in  32  read data from the flash controller.
- m_sel_o  out  4  byte selects to the flash controller.
- m_we_o  out  1  master write enable.
- m_cyc_o  out  1  master cycle.
- m_stb_o  out  1  master strobe.
- m_ack_i  in  1  flash-controller acknowledge.

Function
REQ-003 The block SHALL hold one line: 4 x 32-bit words, tag = s_adr_i[adr_width-1:4], and valid bit.
REQ-004 The block SHALL use these states: IDLE, FILL, WRITE, ACK.
REQ-005 IDLE -> request: s_cyc_i & s_stb_i & ~s_we_i with valid & tag match (hit) SHALL go to ACK and load s_dat_o = word[s_adr_i[3:2]]; the ack occurs on the cycle after the request is seen.
REQ-006 Read miss SHALL go to FILL with word index 0 and tag latched from s_adr_i.
REQ-007 FILL master drive:
- m_cyc_o = m_stb_o = 1, m_we_o = 0, m_sel_o = 4'b1111.
- m_adr_o = {tag, index, 2'b00}, with bits above adr_width zero.
REQ-008 FILL ack handling: each m_ack_i SHALL store m_dat_i to word[index] and increment index.
- The address advances on the same edge and m_stb_o stays high.
- On the ack of index 3: valid <= 1, then go to ACK with s_dat_o = requested word.
REQ-009 Line words SHALL always be fetched in order 0,1,2,3 regardless of the requested word (no critical-word-first).
REQ-010 Write request in IDLE SHALL go to WRITE, driving:
- m_cyc_o = m_stb_o = m_we_o = 1.
- m_adr_o = s_adr_i, m_dat_o = s_dat_i, m_sel_o = s_sel_i.
REQ-011 In WRITE, m_ack_i SHALL deassert the master strobes on the next edge and go to ACK; if tag matches, valid SHALL be cleared.
REQ-012 ACK SHALL assert s_ack_o for exactly one cycle, only if s_cyc_i & s_stb_i are still high, then return to IDLE.
REQ-013 s_ack_o SHALL never be asserted in consecutive cycles; every request SHALL see a minimum one idle cycle.
REQ-014 CPU abort: if s_cyc_i drops during FILL, the fill SHALL complete and the line becomes valid; no s_ack_o is issued.
REQ-015 CPU abort during WRITE: the master write SHALL complete; no s_ack_o is issued.
REQ-016 inval pulse:
- Clears valid in any state.
- If asserted during FILL, the fill completes but valid SHALL remain 0 (the ack is still given).
REQ-017 Reads SHALL return the full 32-bit word regardless of s_sel_i; byte lane selection is the CPU's job.
REQ-018 m_cyc_o and m_stb_o SHALL be low in IDLE and ACK.

Reset
REQ-019 sys_rst SHALL force these values on the next edge, including mid-FILL or mid-WRITE:
- state = IDLE, valid = 0, index = 0.
- s_ack_o = 0, m_cyc_o = m_stb_o = m_we_o = 0.
- s_dat_o = 0, m_adr_o = 0, m_sel_o = 0.
REQ-020 Line data SHALL be undefined after reset; it is never returned while valid = 0.

Verification
REQ-021 Cold read miss: read 0x00000108 -> exactly 4 master reads at 0x100, 0x104, 0x108, 0x10C; s_ack_o one cycle after the 4th m_ack_i; s_dat_o = model word at 0x108.
REQ-022 Hit: read 0x0000010C after REQ-021 -> no master activity; s_ack_o 2 cycles after request; data = word at 0x10C.
REQ-023 Write invalidate: write 0x0000DEAD to 0x104 with s_sel_i = 4'b0011 -> one master write with m_sel_o = 4'b0011; valid cleared; next read of 0x100 refetches 4 words.
REQ-024 Abort and reset:
- Drop s_cyc_i after the 2nd fill ack -> fill completes, no s_ack_o, line valid.
- Assert sys_rst mid-fill -> all master strobes low next cycle, valid = 0.
REQ-025 inval during fill: pulse inval between the 1st and 2nd fill acks -> CPU is acked with correct data; an immediate reread of the same address misses and refills.
REQ-026 Back-to-back hits: two reads with s_stb_i held high -> s_ack_o pulses never adjacent; data correct for both addresses.
